// File: rtl/ordenador_secuencial.sv
// rtl/ordenador_secuencial.sv - sequential bubble sort of N_ELEM 4-bit values via an external A<B comparator
// Optional early exit on a swap-free pass: define ORDEN_SALIDA_TEMPRANA_EN.
module ordenador_secuencial #(
    parameter int N_ELEM = 4,
    parameter int W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_ELEM*W-1:0] data_in,
    output logic [W-1:0]        cmp_a,
    output logic [W-1:0]        cmp_b,
    input  logic                cmp_menor,
    output logic                busy,
    output logic                done,
    output logic [N_ELEM*W-1:0] data_out
);

    localparam int IW = $clog2(N_ELEM);
    localparam logic [IW-1:0] LAST = IW'(N_ELEM - 2);

    generate
        if (W != 4) begin : g_w_check
            $error("ordenador_secuencial: W must be 4 to match the comparator");
        end
        if (N_ELEM < 2 || N_ELEM > 8) begin : g_n_check
            $error("ordenador_secuencial: N_ELEM must be within 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COMPARA,
        FIN
    } state_t;

    state_t                state_q;
    logic [W-1:0]          elem_q [N_ELEM];
    logic [IW-1:0]         p_q;
    logic [IW-1:0]         j_q;
    logic [IW-1:0]         j_inc;
    logic                  busy_q;
    logic                  done_q;
    logic [N_ELEM*W-1:0]   data_out_q;
`ifdef ORDEN_SALIDA_TEMPRANA_EN
    logic                  swap_q;
`endif

    // The comparator sees the upper neighbour on A, so menor=1 means the pair is out of order.
    always_comb begin
        j_inc = j_q + 1'b1;
        cmp_a = '0;
        cmp_b = '0;
        if (state_q == COMPARA) begin
            cmp_a = elem_q[j_inc];
            cmp_b = elem_q[j_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p_q        <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                elem_q[i] <= '0;
            end
`ifdef ORDEN_SALIDA_TEMPRANA_EN
            swap_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            elem_q[i] <= data_in[i*W +: W];
                        end
                        p_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COMPARA;
`ifdef ORDEN_SALIDA_TEMPRANA_EN
                        swap_q  <= 1'b0;
`endif
                    end
                end
                COMPARA: begin
                    if (cmp_menor) begin
                        elem_q[j_q]   <= elem_q[j_inc];
                        elem_q[j_inc] <= elem_q[j_q];
                    end
                    if (j_q < LAST - p_q) begin
                        j_q <= j_inc;
`ifdef ORDEN_SALIDA_TEMPRANA_EN
                        swap_q <= swap_q | cmp_menor;
`endif
                    end else begin
                        j_q <= '0;
                        p_q <= p_q + 1'b1;
`ifdef ORDEN_SALIDA_TEMPRANA_EN
                        swap_q <= 1'b0;
                        // A pass with no swap proves the vector is already ordered.
                        if (p_q == LAST || !(swap_q | cmp_menor)) begin
                            state_q <= FIN;
                        end
`else
                        if (p_q == LAST) begin
                            state_q <= FIN;
                        end
`endif
                    end
                end
                FIN: begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        data_out_q[i*W +: W] <= elem_q[i];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_ordenador_secuencial.sv
// tb/tb_ordenador_secuencial.sv - self-checking bench for ordenador_secuencial
// Early-exit expectations follow ORDEN_SALIDA_TEMPRANA_EN.
module tb_ordenador_secuencial;

    localparam int N = 4;
`ifdef ORDEN_SALIDA_TEMPRANA_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  cmp_a;
    logic [3:0]  cmp_b;
    logic        cmp_menor;
    logic        busy;
    logic        done;
    logic [15:0] data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External 4-bit unsigned A<B comparator.
    assign cmp_menor = (cmp_a < cmp_b);

    ordenador_secuencial #(.N_ELEM(N), .W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .cmp_menor(cmp_menor),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sort is a list of pending compare pairs plus the final result.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_out  = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic [7:0]  m_pairs[$];

    task automatic model_sort(input logic [15:0] v);
        logic [3:0] e [N];
        logic [3:0] t;
        bit sw;
        for (int i = 0; i < N; i++) e[i] = v[4*i +: 4];
        m_pairs.delete();
        for (int p = 0; p < N - 1; p++) begin
            sw = 1'b0;
            for (int j = 0; j < N - 1 - p; j++) begin
                m_pairs.push_back({e[j+1], e[j]});
                if (e[j+1] < e[j]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                    sw = 1'b1;
                end
            end
            if (EARLY && !sw) break;
        end
        for (int i = 0; i < N; i++) m_pend[4*i +: 4] = e[i];
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = 16'h0;
            m_pairs.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    model_sort(data_in);
                    m_busy = 1'b1;
                end
            end else if (m_pairs.size() > 0) begin
                void'(m_pairs.pop_front());
            end else begin
                m_out  = m_pend;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    initial forever begin
        logic [7:0] exp_ab;
        @(negedge clk);
        exp_ab = (m_busy && m_pairs.size() > 0) ? m_pairs[0] : 8'h00;
        check("cyc_busy", busy, m_busy);
        check("cyc_done", done, m_done);
        check("cyc_data_out", data_out, m_out);
        check("cyc_cmp_ab", {cmp_a, cmp_b}, exp_ab);
    end

    logic [7:0] log_q[$];

    task automatic run_sort(input string tag, input logic [15:0] vec, input logic [15:0] exp_out,
                            input int exp_lat, input int exp_swaps);
        int n;
        int swaps;
        bit got;
        n = 0; swaps = 0; got = 1'b0;
        log_q.delete();
        @(negedge clk);
        data_in = vec;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1'b1);
        while (n < 40) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (cmp_a < cmp_b) swaps++;
            log_q.push_back({cmp_a, cmp_b});
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, got ? n : -1, exp_lat);
        check({tag, "_data_out"}, data_out, exp_out);
        check({tag, "_swaps"}, swaps, exp_swaps);
        check({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        int dones;
        int times[$];
        logic [7:0] rev_pairs [6];
        rev_pairs = '{8'h23, 8'h13, 8'h03, 8'h12, 8'h02, 8'h01};

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data_out", data_out, 16'h0);
        check("rst_cmp", {cmp_a, cmp_b}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_sort("mixed", 16'h193F, 16'hF931, 7, 5);
        run_sort("reverse", 16'h0123, 16'h3210, 7, 6);
        for (int i = 0; i < 6; i++) begin
            if (log_q.size() > i) check("reverse_pair", log_q[i], rev_pairs[i]);
            else check("reverse_pair_missing", 0, 1);
        end
        run_sort("dups", 16'h3333, 16'h3333, EARLY ? 4 : 7, 0);
        run_sort("ties", 16'h5151, 16'h5511, EARLY ? 6 : 7, 1);
        run_sort("sorted", 16'hFA51, 16'hFA51, EARLY ? 4 : 7, 0);

        // start pulses and data_in changes during a sort are ignored
        @(negedge clk);
        data_in = 16'h0123;
        start   = 1'b1;
        @(posedge clk);
        n = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 1) begin start = 1'b1; data_in = 16'h193F; end
            if (c == 2) begin start = 1'b0; data_in = 16'hFFFF; end
            if (done) begin n = c; break; end
        end
        check("ignore_latency", n, 7);
        check("ignore_data_out", data_out, 16'h3210);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ignore_no_extra_done", dones, 0);

        // start held high: back-to-back sorts
        @(negedge clk);
        data_in = 16'h193F;
        start   = 1'b1;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            if (done) times.push_back(c);
        end
        start = 1'b0;
        check("b2b_count", times.size(), 3);
        if (times.size() >= 3) begin
            check("b2b_first", times[0], 7);
            check("b2b_gap1", times[1] - times[0], 8);
            check("b2b_gap2", times[2] - times[1], 8);
        end
        check("b2b_data_out", data_out, 16'hF931);
        repeat (12) @(negedge clk);

        // reset mid-sort aborts with no done
        @(negedge clk);
        data_in = 16'h0123;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_data_out", data_out, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ordenador_secuencial.md
Name: ordenador_secuencial

Overview:
- Sequential bubble-sort engine for N_ELEM 4-bit values.
- Sits directly upstream of the 4-bit "A < B" comparator.
  - Drives the comparator's A/B inputs through cmp_a/cmp_b.
  - Consumes its single-bit "menor" result through cmp_menor.
  - Swaps elements accordingly.
- One compare-and-swap per clock. Result presented as a registered packed vector with busy/done handshake.

Parameters:
- N_ELEM, 4, number of elements sorted; legal range 2..8.
- W, 4, element width; fixed at 4 to match the comparator; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to sort; sampled only in IDLE.
- data_in  input  N_ELEM*W  packed operands; element i = data_in[4i+3:4i].
- cmp_a  output  4  to comparator A.
- cmp_b  output  4  to comparator B.
- cmp_menor  input  1  comparator result; 1 when cmp_a < cmp_b (unsigned); combinational, same cycle.
- busy  output  1  high while a sort is in progress.
- done  output  1  one-cycle pulse when data_out is valid/updated.
- data_out  output  N_ELEM*W  sorted ascending, element 0 = smallest; held until the next done.

Behaviour:
- State machine: IDLE, COMPARA, FIN. Internal registers:
  - elem[0..N_ELEM-1]
  - pass index p
  - position index j
  - swap flag (used only with the optional feature)
- Reset (async, rst=1):
  - state=IDLE; p=0; j=0.
  - busy=0, done=0, data_out=0; all elem=0.
  - A reset asserted mid-sort aborts the sort; no done is produced for it.
- IDLE:
  - cmp_a=cmp_b=0.
  - On an edge with start=1: elem[i]<=data_in element i; p=0; j=0; busy<=1; state<=COMPARA.
  - start=0: hold.
- COMPARA (combinational compare):
  - cmp_a=elem[j+1], cmp_b=elem[j].
  - At each edge: if cmp_menor=1, swap elem[j] and elem[j+1]; else leave both unchanged.
  - Equal values never swap (stable).
- COMPARA index advance:
  - If j < N_ELEM-2-p: j<=j+1.
  - Else end of pass: j<=0, p<=p+1.
  - Else if p = N_ELEM-2: state<=FIN.
- FIN, at the edge:
  - data_out<=packed elem; done<=1; busy<=0; state<=IDLE.
- done deasserts at the following edge; exactly one cycle high.
- Latency, with start sampled at edge k:
  - Compares occur at edges k+1 .. k+N(N-1)/2.
  - FIN edge is k+1+N(N-1)/2 (k+7 for N_ELEM=4); done high in the cycle after it.
- busy is high from edge k through the FIN edge.
- start is ignored while busy=1; data_in changes during a sort have no effect.
- start=1 during the done cycle (state IDLE) is accepted; a back-to-back sort begins.
- cmp_menor is only used in COMPARA; its value in other states is ignored.

Optional Feature:
- Macro: ORDEN_SALIDA_TEMPRANA_EN.
- Defined (early exit):
  - Swap flag clears at the start of each pass and sets on any swap.
  - At the end of a pass with flag=0, state<=FIN immediately, skipping the remaining passes.
  - Latency becomes data-dependent.
  - Already-sorted input with N_ELEM=4: compares at k+1..k+3, FIN edge k+4.
- Undefined: fixed latency as above; no swap flag logic is synthesized.

Test Plan:
- Mixed input: data_in=16'h193F, start pulse at edge k → done at FIN edge k+7 with data_out=16'hF931; busy high k..k+7.
- Reverse order: data_in=16'h0123 → data_out=16'h3210. Exactly 6 swaps observed, via cmp_a/cmp_b pairs (2,3),(1,3),(0,3),(1,2),(0,2),(0,1) in that order.
- Duplicates: data_in=16'h3333 → no swaps, data_out=16'h3333.
- Ties: data_in=16'h5151 → data_out=16'h5511.
- Already sorted: data_in=16'hFA51 → data_out=16'hFA51.
  - Without the macro: done after edge k+7.
  - With ORDEN_SALIDA_TEMPRANA_EN: done after edge k+4.
- Reset and handshake:
  - Assert rst at edge k+3 of a sort → busy=0, done=0, data_out=0 immediately; no done afterwards.
  - start held high continuously → consecutive sorts every 8 cycles.
  - start pulses while busy → ignored.
